// File: rtl/s_stream_packer_pkg.sv
// Shared constants for the S-path stream packer: array geometry, symbol
// encoding, FIFO depth and packer state encoding.
package s_stream_packer_pkg;

    localparam int PE_ARRAY_SIZE     = 64;
    localparam int PE_ARRAY_SIZE_LOG = 6;

    // The chunk FIFO is a fixed two-entry register FIFO.
    localparam int FIFO_DEPTH = 2;

    localparam logic [1:0] SYM_A = 2'b00;
    localparam logic [1:0] SYM_C = 2'b01;
    localparam logic [1:0] SYM_G = 2'b10;
    localparam logic [1:0] SYM_T = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/s_chunk_fifo.sv
// Two-entry register FIFO holding completed chunks (data, symbol count, eos).
// Reset only clears the pointers and occupancy; stale storage is never read.
module s_chunk_fifo
    import s_stream_packer_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [CNT_W-1:0]  push_cnt_i,
    input  logic              push_eos_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  head_cnt_o,
    output logic              head_eos_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [CNT_W-1:0]  cnt_q  [FIFO_DEPTH];
    logic              eos_q  [FIFO_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;

    // Pointer and occupancy update; simultaneous push and pop keeps occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) wr_ptr_d = ~wr_ptr_q;
        if (pop_i)  rd_ptr_d = ~rd_ptr_q;
        if (push_i && !pop_i)      occ_d = occ_q + 2'd1;
        else if (!push_i && pop_i) occ_d = occ_q - 2'd1;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage, written at the write pointer on push.
    always_ff @(posedge clk) begin
        if (push_i) begin
            data_q[wr_ptr_q] <= push_data_i;
            cnt_q[wr_ptr_q]  <= push_cnt_i;
            eos_q[wr_ptr_q]  <= push_eos_i;
        end
    end

    assign head_data_o = data_q[rd_ptr_q];
    assign head_cnt_o  = cnt_q[rd_ptr_q];
    assign head_eos_o  = eos_q[rd_ptr_q];
    assign full_o      = (occ_q == 2'(FIFO_DEPTH));
    assign empty_o     = (occ_q == 2'd0);

endmodule

// File: rtl/s_stream_packer.sv
// S-path stream packer: packs 2-bit host symbols into N-symbol chunks,
// buffers them in a 2-entry FIFO and returns one chunk per request.
// Optional: define S_PACK_LEN_EN to add o_s_len, the saturating count of
// symbols accepted since the last start.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset; waiting for i_start
// ST_FILL  | accepting symbols until the last one is taken
// ST_DRAIN | no more symbols; serving chunks until the eos chunk leaves
// ST_DONE  | sequence complete; waiting for the next i_start
module s_stream_packer #(
    parameter int PE_ARRAY_SIZE     = s_stream_packer_pkg::PE_ARRAY_SIZE,
    parameter int PE_ARRAY_SIZE_LOG = s_stream_packer_pkg::PE_ARRAY_SIZE_LOG
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic                         i_sym_valid,
    input  logic [1:0]                   i_sym,
    input  logic                         i_sym_last,
    output logic                         o_sym_ready,
    input  logic                         i_request_s,
    output logic [2*PE_ARRAY_SIZE-1:0]   o_s,
    output logic [PE_ARRAY_SIZE_LOG:0]   o_s_valid,
    output logic                         o_s_eos,
    output logic                         o_busy
`ifdef S_PACK_LEN_EN
    ,
    output logic [15:0]                  o_s_len
`endif
);

    import s_stream_packer_pkg::*;

    localparam int N  = PE_ARRAY_SIZE;
    localparam int DW = 2 * PE_ARRAY_SIZE;
    localparam int CW = PE_ARRAY_SIZE_LOG + 1;

    state_e          state_q, state_d;
    logic [DW-1:0]   asm_q, asm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            eos_q, eos_d;
    logic            hold_q, hold_d;
    logic            ready_q, ready_d;
    logic            pend_q, pend_d;
    logic [DW-1:0]   os_q, os_d;
    logic [CW-1:0]   osv_q, osv_d;
    logic            oseos_q, oseos_d;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0]   head_data;
    logic [CW-1:0]   head_cnt;
    logic            head_eos;

    logic            active, start_go, accept;
    logic            push_cand, req_new, want, serve_fifo, serve_byp, serve_eos;
    logic [CW-1:0]   cnt_inc;
    logic [DW-1:0]   sym_pos;

    assign active   = (state_q == ST_FILL) || (state_q == ST_DRAIN);
    assign start_go = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept   = i_sym_valid && ready_q;
    assign cnt_inc  = cnt_q + 1'b1;
    // New symbol lands just below the ones already collected, so the chunk
    // is left-aligned with zeros in the unused low bits.
    assign sym_pos  = {i_sym, {(DW-2){1'b0}}} >> {cnt_q, 1'b0};

    // A completed chunk leaves the assembler when the FIFO has room. A request
    // is taken from the FIFO head, or straight from the assembler when the
    // FIFO is empty and a chunk is leaving this cycle (serves a pending request).
    assign push_cand  = hold_q && !fifo_full;
    assign req_new    = i_request_s && active && !pend_q && (osv_q == '0);
    assign want       = pend_q || req_new;
    assign serve_fifo = want && !fifo_empty;
    assign serve_byp  = want && fifo_empty && push_cand;
    assign fifo_push  = push_cand && !serve_byp;
    assign fifo_pop   = serve_fifo;
    assign serve_eos  = (serve_fifo && head_eos) || (serve_byp && eos_q);

    // Next-state logic for the sequence FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_FILL;
            ST_FILL:  if (accept && i_sym_last) state_d = ST_DRAIN;
            ST_DRAIN: if (serve_eos) state_d = ST_DONE;
            ST_DONE:  if (i_start) state_d = ST_FILL;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Assembler, pending request and output register next values.
    always_comb begin
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        eos_d   = eos_q;
        hold_d  = hold_q;
        pend_d  = 1'b0;
        os_d    = os_q;
        osv_d   = '0;
        oseos_d = 1'b0;

        if (push_cand) begin
            asm_d  = '0;
            cnt_d  = '0;
            eos_d  = 1'b0;
            hold_d = 1'b0;
        end
        if (accept) begin
            asm_d = asm_q | sym_pos;
            cnt_d = cnt_inc;
            if ((cnt_inc == CW'(N)) || i_sym_last) begin
                hold_d = 1'b1;
                eos_d  = i_sym_last;
            end
        end
        if (start_go) begin
            asm_d  = '0;
            cnt_d  = '0;
            eos_d  = 1'b0;
            hold_d = 1'b0;
        end

        pend_d = active && want && !serve_fifo && !serve_byp;

        if (serve_fifo) begin
            os_d    = head_data;
            osv_d   = head_cnt;
            oseos_d = head_eos;
        end else if (serve_byp) begin
            os_d    = asm_q;
            osv_d   = cnt_q;
            oseos_d = eos_q;
        end

        ready_d = (state_d == ST_FILL) && !hold_d;
    end

    // All packer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            asm_q   <= '0;
            cnt_q   <= '0;
            eos_q   <= 1'b0;
            hold_q  <= 1'b0;
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
            os_q    <= '0;
            osv_q   <= '0;
            oseos_q <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            eos_q   <= eos_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
            pend_q  <= pend_d;
            os_q    <= os_d;
            osv_q   <= osv_d;
            oseos_q <= oseos_d;
        end
    end

    s_chunk_fifo #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (asm_q),
        .push_cnt_i  (cnt_q),
        .push_eos_i  (eos_q),
        .pop_i       (fifo_pop),
        .head_data_o (head_data),
        .head_cnt_o  (head_cnt),
        .head_eos_o  (head_eos),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef S_PACK_LEN_EN
    logic [15:0] len_q, len_d;

    // Saturating count of accepted symbols, cleared on start.
    always_comb begin
        len_d = len_q;
        if (start_go) len_d = '0;
        else if (accept && (len_q != 16'hFFFF)) len_d = len_q + 16'd1;
    end

    // Length counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) len_q <= '0;
        else        len_q <= len_d;
    end

    assign o_s_len = len_q;
`endif

    assign o_sym_ready = ready_q;
    assign o_s         = os_q;
    assign o_s_valid   = osv_q;
    assign o_s_eos     = oseos_q;
    assign o_busy      = active;

endmodule

// File: tb/tb_s_stream_packer.sv
// Directed bench for s_stream_packer with a 4-symbol PE array.
module tb_s_stream_packer;

    localparam int N   = 4;
    localparam int LOG = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_start;
    logic           i_sym_valid;
    logic [1:0]     i_sym;
    logic           i_sym_last;
    logic           o_sym_ready;
    logic           i_request_s;
    logic [2*N-1:0] o_s;
    logic [LOG:0]   o_s_valid;
    logic           o_s_eos;
    logic           o_busy;
`ifdef S_PACK_LEN_EN
    logic [15:0]    o_s_len;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    s_stream_packer #(
        .PE_ARRAY_SIZE     (N),
        .PE_ARRAY_SIZE_LOG (LOG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_sym_valid (i_sym_valid),
        .i_sym       (i_sym),
        .i_sym_last  (i_sym_last),
        .o_sym_ready (o_sym_ready),
        .i_request_s (i_request_s),
        .o_s         (o_s),
        .o_s_valid   (o_s_valid),
        .o_s_eos     (o_s_eos),
        .o_busy      (o_busy)
`ifdef S_PACK_LEN_EN
        ,
        .o_s_len     (o_s_len)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic request();
        i_request_s = 1'b1;
        tick();
        i_request_s = 1'b0;
    endtask

    // Streams symbols 0,1,2,3,0,... holding valid until each is accepted.
    task automatic send_syms(input int n, input bit last);
        int   i;
        int   budget;
        logic rdy;
        i = 0;
        budget = 0;
        while (i < n && budget < 100) begin
            i_sym_valid = 1'b1;
            i_sym       = 2'(i % 4);
            i_sym_last  = last && (i == n - 1);
            rdy = o_sym_ready;
            tick();
            if (rdy) i++;
            budget++;
        end
        i_sym_valid = 1'b0;
        i_sym_last  = 1'b0;
        check("send_count", i, n);
    endtask

    initial begin
        int   sent, nvalid, acc;
        logic seen;
        logic [LOG:0]   cap_cnt;
        logic [2*N-1:0] cap_s;

        rst_n = 1'b0; i_start = 1'b0; i_sym_valid = 1'b0; i_sym = 2'b00;
        i_sym_last = 1'b0; i_request_s = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        check("rst_ready", o_sym_ready, 0);
        check("rst_s",     o_s, 0);
        check("rst_valid", o_s_valid, 0);
        check("rst_eos",   o_s_eos, 0);
        check("rst_busy",  o_busy, 0);

        // 10 symbols -> chunks 1B/4, 1B/4, 10/2 eos
        do_start();
        check("t1_busy", o_busy, 1);
        check("t1_ready", o_sym_ready, 1);
        send_syms(10, 1'b1);
        repeat (5) tick();
        request();
        check("t1_c1_cnt", o_s_valid, 4);
        check("t1_c1_s",   o_s, 8'h1B);
        check("t1_c1_eos", o_s_eos, 0);
        tick();
        check("t1_c1_once", o_s_valid, 0);
        check("t1_s_hold",  o_s, 8'h1B);
        repeat (8) tick();
        request();
        check("t1_c2_cnt", o_s_valid, 4);
        check("t1_c2_s",   o_s, 8'h1B);
        check("t1_c2_eos", o_s_eos, 0);
        repeat (9) tick();
        request();
        check("t1_c3_cnt",  o_s_valid, 2);
        check("t1_c3_s",    o_s, 8'h10);
        check("t1_c3_eos",  o_s_eos, 1);
        check("t1_c3_busy", o_busy, 0);
        tick();
        check("t1_eos_low", o_s_eos, 0);

        // exact multiple of N: last full chunk carries eos
        do_start();
        send_syms(8, 1'b1);
        repeat (3) tick();
        request();
        check("t2_c1_cnt", o_s_valid, 4);
        check("t2_c1_eos", o_s_eos, 0);
        repeat (3) tick();
        request();
        check("t2_c2_cnt",  o_s_valid, 4);
        check("t2_c2_s",    o_s, 8'h1B);
        check("t2_c2_eos",  o_s_eos, 1);
        check("t2_c2_busy", o_busy, 0);
        repeat (3) tick();
        request();
        check("t2_c3_none", o_s_valid, 0);
        tick();
        check("t2_c3_none2", o_s_valid, 0);

        // request before symbols: latched and served once on first push
        do_start();
        request();
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (o_s_valid != 0) seen = 1'b1;
        end
        check("t3_no_early", seen, 0);
        sent = 0; nvalid = 0; cap_cnt = '0; cap_s = '0;
        for (int c = 0; c < 15; c++) begin
            logic rdy;
            i_sym_valid = (sent < 4);
            i_sym = 2'(sent % 4);
            rdy = o_sym_ready;
            tick();
            if (rdy && sent < 4) sent++;
            if (o_s_valid != 0) begin
                nvalid++;
                cap_cnt = o_s_valid;
                cap_s   = o_s;
            end
        end
        i_sym_valid = 1'b0;
        check("t3_once", nvalid, 1);
        check("t3_cnt",  cap_cnt, 4);
        check("t3_s",    cap_s, 8'h1B);

        // reset mid-FILL
        check("t5_pre_busy", o_busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_ready", o_sym_ready, 0);
        check("t5_s",     o_s, 0);
        check("t5_valid", o_s_valid, 0);
        check("t5_eos",   o_s_eos, 0);
        check("t5_busy",  o_busy, 0);
        request();
        tick();
        check("t5_req_none", o_s_valid, 0);
        i_sym_valid = 1'b1;
        tick();
        check("t5_idle_ready", o_sym_ready, 0);
        i_sym_valid = 1'b0;

        // backpressure: 2 FIFO entries + 1 held chunk = 12 symbols
        do_start();
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            logic rdy;
            i_sym_valid = (acc < 16);
            i_sym = 2'(acc % 4);
            rdy = o_sym_ready;
            tick();
            if (rdy && acc < 16) acc++;
        end
        i_sym_valid = 1'b0;
        check("t4_accepted", acc, 12);
        check("t4_ready_low", o_sym_ready, 0);
        request();
        check("t4_cnt", o_s_valid, 4);
        check("t4_s",   o_s, 8'h1B);
        seen = 1'b0;
        repeat (2) begin
            tick();
            if (o_sym_ready) seen = 1'b1;
        end
        check("t4_ready_back", seen, 1);

`ifdef S_PACK_LEN_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        do_start();
        send_syms(5, 1'b1);
        repeat (3) tick();
        request();
        repeat (3) tick();
        request();
        check("len_busy", o_busy, 0);
        check("len_done", o_s_len, 5);
        do_start();
        check("len_clear", o_s_len, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1);
    end

endmodule
